// File: rtl/mcoi_xu5_system_pkg.sv
// MCOI XU5 shared types: motor payload fields, interlock key,
// clock/reset bundle and serial register FSM states.
package MCPkg;

  localparam int NUMBER_OF_MOTORS_PER_FIBER = 16;
  localparam logic [31:0] GEFE_INTERLOCK = 32'h4745_4645;

  typedef struct packed {
    logic       OH_i;
    logic       StepPFail_i;
    logic [1:0] RawSwitches_b2;
  } mcinput_t;

  typedef struct packed {
    logic StepBOOST_o;
    logic StepDIR_o;
    logic StepDeactivate_o;
    logic StepOutP_o;
  } mcoutput_t;

  typedef struct packed {
    logic clk;
    logic reset_n;
  } ckrs_t;

  typedef enum logic {
    RX_HUNT,
    RX_SHIFT
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/mcoi_xu5_system_if.sv
// GBT frame and motor pin bundle of the MCOI XU5 data path.
interface mcoi_xu5_system_if;
  logic [1:0]  ScRx_ib2;
  logic [1:0]  ScTx_ob2;
  logic [63:0] MotorDataRx_ib64;
  logic [63:0] MotorDataTx_ob64;
  logic [15:0] PlPfail_ib16;
  logic [15:0] PlSwOutA_ib16;
  logic [15:0] PlSwOutB_ib16;
  logic [15:0] PlBoost_ob16;
  logic [15:0] PlDir_ob16;
  logic [15:0] PlEn_ob16;
  logic [15:0] PlClk_ob16;

  modport master (
    output ScRx_ib2, MotorDataRx_ib64,
    output PlPfail_ib16, PlSwOutA_ib16, PlSwOutB_ib16,
    input  ScTx_ob2, MotorDataTx_ob64,
    input  PlBoost_ob16, PlDir_ob16, PlEn_ob16, PlClk_ob16
  );

  modport slave (
    input  ScRx_ib2, MotorDataRx_ib64,
    input  PlPfail_ib16, PlSwOutA_ib16, PlSwOutB_ib16,
    output ScTx_ob2, MotorDataTx_ob64,
    output PlBoost_ob16, PlDir_ob16, PlEn_ob16, PlClk_ob16
  );
endinterface

// File: rtl/mcoi_xu5_system_serial_register.sv
// SC serial word channel: frame is a '1' start bit, 32 data bits
// MSB first, then a '0' stop bit; TX repeats frames continuously.
module serial_register
  import MCPkg::*;
(
  input  ckrs_t       ClkRs_ix,
  input  ckrs_t       ClkRxGBT_ix,
  input  ckrs_t       ClkTxGBT_ix,
  input  logic        resetflags_i,
  input  logic [31:0] data_ib32,
  output logic [31:0] data_ob32,
  input  logic        Rx_i,
  output logic        Tx_o,
  output logic        RxLocked_o,
  output logic        TxBusy_o
);

  logic sys_clk, sys_rst_n;
  logic rx_clk, rx_rst_n;
  logic tx_clk, tx_rst_n;

  assign sys_clk   = ClkRs_ix.clk;
  assign sys_rst_n = ClkRs_ix.reset_n;
  assign rx_clk    = ClkRxGBT_ix.clk;
  assign rx_rst_n  = ClkRxGBT_ix.reset_n;
  assign tx_clk    = ClkTxGBT_ix.clk;
  assign tx_rst_n  = ClkTxGBT_ix.reset_n;

  rx_state_t   rx_st;
  logic [4:0]  rx_cnt;
  logic [31:0] rx_sr;
  logic [31:0] rx_word;
  logic        rx_lock;

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      rx_st   <= RX_HUNT;
      rx_cnt  <= '0;
      rx_sr   <= '0;
      rx_word <= '0;
      rx_lock <= 1'b0;
    end else begin
      if (resetflags_i) rx_lock <= 1'b0;
      unique case (rx_st)
        RX_HUNT: begin
          if (Rx_i) begin
            rx_st  <= RX_SHIFT;
            rx_cnt <= '0;
          end
        end
        RX_SHIFT: begin
          rx_sr  <= {rx_sr[30:0], Rx_i};
          rx_cnt <= rx_cnt + 5'd1;
          if (rx_cnt == 5'd31) begin
            rx_word <= {rx_sr[30:0], Rx_i};
            rx_lock <= 1'b1;
            rx_st   <= RX_HUNT;
          end
        end
      endcase
    end
  end

  // Decoded word handed over to the system domain.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_ob32  <= '0;
      RxLocked_o <= 1'b0;
    end else begin
      data_ob32  <= rx_word;
      RxLocked_o <= rx_lock;
    end
  end

  tx_state_t   tx_st;
  logic [4:0]  tx_cnt;
  logic [31:0] tx_sr;

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      tx_st    <= TX_START;
      tx_cnt   <= '0;
      tx_sr    <= '0;
      Tx_o     <= 1'b0;
      TxBusy_o <= 1'b0;
    end else begin
      unique case (tx_st)
        TX_START: begin
          Tx_o     <= 1'b1;
          TxBusy_o <= 1'b1;
          tx_sr    <= data_ib32;
          tx_cnt   <= '0;
          tx_st    <= TX_DATA;
        end
        TX_DATA: begin
          Tx_o   <= tx_sr[31];
          tx_sr  <= {tx_sr[30:0], 1'b0};
          tx_cnt <= tx_cnt + 5'd1;
          if (tx_cnt == 5'd31) tx_st <= TX_STOP;
        end
        TX_STOP: begin
          Tx_o     <= 1'b0;
          TxBusy_o <= 1'b0;
          tx_st    <= TX_START;
        end
        default: tx_st <= TX_START;
      endcase
    end
  end

endmodule

// File: rtl/mcoi_xu5_system.sv
// MCOI XU5 core data path: SC interlock/page channels, motor
// command pin drive and status/loopback GBT payload.
module mcoi_xu5_system
  import MCPkg::*;
#(
  parameter logic [30:0] g_BuildNumber = 31'd1,
  parameter int          g_NumMotors   = NUMBER_OF_MOTORS_PER_FIBER
) (
  input logic               Clk_ik,
  input logic               Rst_irn,
  mcoi_xu5_system_if.slave  bus
);

  ckrs_t clk_rs;
  assign clk_rs.clk     = Clk_ik;
  assign clk_rs.reset_n = Rst_irn;

  logic [31:0] rx_word0, rx_word1, tx_word0;
  logic        locked0, locked1;
  logic        link_closed, gbt_loop_en;
  logic [30:0] page;

  serial_register u_sc0 (
    .ClkRs_ix     (clk_rs),
    .ClkRxGBT_ix  (clk_rs),
    .ClkTxGBT_ix  (clk_rs),
    .resetflags_i (1'b0),
    .data_ib32    (tx_word0),
    .data_ob32    (rx_word0),
    .Rx_i         (bus.ScRx_ib2[0]),
    .Tx_o         (bus.ScTx_ob2[0]),
    .RxLocked_o   (locked0),
    .TxBusy_o     ()
  );

  serial_register u_sc1 (
    .ClkRs_ix     (clk_rs),
    .ClkRxGBT_ix  (clk_rs),
    .ClkTxGBT_ix  (clk_rs),
    .resetflags_i (1'b0),
    .data_ib32    (rx_word1),
    .data_ob32    (rx_word1),
    .Rx_i         (bus.ScRx_ib2[1]),
    .Tx_o         (bus.ScTx_ob2[1]),
    .RxLocked_o   (locked1),
    .TxBusy_o     ()
  );

  assign link_closed = locked1 && (rx_word1 == GEFE_INTERLOCK);
  assign gbt_loop_en = locked0 && rx_word0[31];
  assign page        = rx_word0[30:0];

  always_comb begin
    tx_word0 = {gbt_loop_en, 31'd0};
    unique case (1'b1)
      (page == 31'd0): tx_word0 = {gbt_loop_en, g_BuildNumber};
      (page == 31'd1): tx_word0 = rx_word1;
      default:         tx_word0 = {gbt_loop_en, 31'd0};
    endcase
  end

  logic [15:0] boost_d, dir_d, en_d, clk_d;
  mcoutput_t   cmd;

  always_comb begin
    boost_d = '0;
    dir_d   = '0;
    en_d    = '0;
    clk_d   = '0;
    cmd     = '0;
    for (int m = 0; m < g_NumMotors; m++) begin
      cmd        = bus.MotorDataRx_ib64[4*m +: 4];
      boost_d[m] = cmd.StepBOOST_o;
      dir_d[m]   = cmd.StepDIR_o;
      en_d[m]    = cmd.StepDeactivate_o;
      clk_d[m]   = cmd.StepOutP_o;
    end
  end

  always_ff @(posedge Clk_ik or negedge Rst_irn) begin
    if (!Rst_irn) begin
      bus.PlBoost_ob16 <= '0;
      bus.PlDir_ob16   <= '0;
      bus.PlEn_ob16    <= '0;
      bus.PlClk_ob16   <= '0;
    end else if (link_closed) begin
      bus.PlBoost_ob16 <= boost_d;
      bus.PlDir_ob16   <= dir_d;
      bus.PlEn_ob16    <= en_d;
      bus.PlClk_ob16   <= clk_d;
    end else begin
      bus.PlBoost_ob16 <= '0;
      bus.PlDir_ob16   <= '0;
      bus.PlEn_ob16    <= '0;
      bus.PlClk_ob16   <= '0;
    end
  end

  // Pin status inputs are asynchronous to the frame clock.
  logic [47:0] st_s1, st_s2;

  always_ff @(posedge Clk_ik or negedge Rst_irn) begin
    if (!Rst_irn) begin
      st_s1 <= '0;
      st_s2 <= '0;
    end else begin
      st_s1 <= {bus.PlSwOutB_ib16, bus.PlSwOutA_ib16,
                bus.PlPfail_ib16};
      st_s2 <= st_s1;
    end
  end

  logic [63:0] st_word;
  mcinput_t    sw;

  always_comb begin
    st_word = '0;
    sw      = '0;
    for (int m = 0; m < g_NumMotors; m++) begin
      sw.OH_i           = 1'b0;
      sw.StepPFail_i    = st_s2[m];
      sw.RawSwitches_b2 = {st_s2[32+m], st_s2[16+m]};
      st_word[4*m +: 4] = sw;
    end
  end

  always_ff @(posedge Clk_ik or negedge Rst_irn) begin
    if (!Rst_irn) begin
      bus.MotorDataTx_ob64 <= '0;
    end else if (gbt_loop_en) begin
      bus.MotorDataTx_ob64 <= bus.MotorDataRx_ib64;
    end else begin
      bus.MotorDataTx_ob64 <= st_word;
    end
  end

endmodule

// File: tb/tb_mcoi_xu5_system.sv
// Directed/random bench for mcoi_xu5_system with a behavioural
// payload model and a free-running SC frame receiver.
module tb_mcoi_xu5_system;
  import MCPkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mcoi_xu5_system_if bus ();

  mcoi_xu5_system dut (
    .Clk_ik  (clk),
    .Rst_irn (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #12 clk = ~clk;

  int          rcv_st[2];
  int          rcv_cnt[2];
  logic [31:0] rcv_sr[2];
  logic [31:0] rcv_word[2];
  int          rcv_frames[2];

  initial begin
    for (int c = 0; c < 2; c++) begin
      rcv_st[c]     = 0;
      rcv_cnt[c]    = 0;
      rcv_sr[c]     = '0;
      rcv_word[c]   = '0;
      rcv_frames[c] = 0;
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        rcv_st[c]  = 0;
        rcv_cnt[c] = 0;
      end else if (rcv_st[c] == 0) begin
        if (bus.ScTx_ob2[c]) begin
          rcv_st[c]  = 1;
          rcv_cnt[c] = 0;
        end
      end else begin
        rcv_sr[c]  = {rcv_sr[c][30:0], bus.ScTx_ob2[c]};
        rcv_cnt[c] = rcv_cnt[c] + 1;
        if (rcv_cnt[c] == 32) begin
          rcv_word[c]   = rcv_sr[c];
          rcv_frames[c] = rcv_frames[c] + 1;
          rcv_st[c]     = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pins_model(
      input logic [63:0] rx, input bit link);
    logic [15:0] b, d, e, k;
    b = '0; d = '0; e = '0; k = '0;
    for (int m = 1; m <= 16; m++) begin
      if (link) begin
        b[m-1] = rx[4*m-1];
        d[m-1] = rx[4*m-2];
        e[m-1] = rx[4*m-3];
        k[m-1] = rx[4*m-4];
      end
    end
    return {b, d, e, k};
  endfunction

  function automatic logic [63:0] status_model(
      input logic [15:0] pf, input logic [15:0] a,
      input logic [15:0] b);
    logic [63:0] w;
    w = '0;
    for (int m = 1; m <= 16; m++)
      w[4*m-4 +: 4] = {1'b0, pf[m-1], b[m-1], a[m-1]};
    return w;
  endfunction

  function automatic logic [63:0] pins_now();
    return {bus.PlBoost_ob16, bus.PlDir_ob16,
            bus.PlEn_ob16, bus.PlClk_ob16};
  endfunction

  task automatic write_ch(input int ch, input logic [31:0] w);
    @(negedge clk) bus.ScRx_ib2[ch] = 1'b1;
    for (int i = 31; i >= 0; i--)
      @(negedge clk) bus.ScRx_ib2[ch] = w[i];
    @(negedge clk) bus.ScRx_ib2[ch] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic read_ch(input int ch, input string tag,
                         input logic [31:0] exp);
    int start;
    int n;
    start = rcv_frames[ch];
    n = 0;
    while (rcv_frames[ch] < start + 2 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (rcv_frames[ch] < start + 2) begin
      total++;
      bad++;
      $error("FAIL %s_timeout observed=%0d expected=%0d",
             tag, rcv_frames[ch] - start, 2);
    end else begin
      chk(tag, {32'd0, rcv_word[ch]}, {32'd0, exp});
    end
  endtask

  logic [63:0] rx;
  logic [15:0] pf, sa, sb;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.ScRx_ib2         = '0;
    bus.MotorDataRx_ib64 = '0;
    bus.PlPfail_ib16     = '0;
    bus.PlSwOutA_ib16    = '0;
    bus.PlSwOutB_ib16    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pins", pins_now(), 64'd0);
    chk("rst_tx", bus.MotorDataTx_ob64, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      rx = {$urandom, $urandom};
      bus.MotorDataRx_ib64 = rx;
      @(posedge clk) #1;
      chk("open_pins", pins_now(), pins_model(rx, 1'b0));
    end

    read_ch(0, "ch0_build", 32'h0000_0001);

    write_ch(1, GEFE_INTERLOCK);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      rx = {$urandom, $urandom};
      bus.MotorDataRx_ib64 = rx;
      @(posedge clk) #1;
      chk("closed_pins", pins_now(), pins_model(rx, 1'b1));
    end

    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      pf = 16'($urandom);
      sa = 16'($urandom);
      sb = 16'($urandom);
      bus.PlPfail_ib16     = pf;
      bus.PlSwOutA_ib16    = sa;
      bus.PlSwOutB_ib16    = sb;
      bus.MotorDataRx_ib64 = {$urandom, $urandom};
      repeat (3) @(posedge clk);
      #1;
      chk("status", bus.MotorDataTx_ob64, status_model(pf, sa, sb));
    end

    write_ch(0, 32'h8000_0000);
    read_ch(0, "ch0_loop", 32'h8000_0001);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      rx = {$urandom, $urandom};
      bus.MotorDataRx_ib64 = rx;
      bus.PlPfail_ib16     = 16'($urandom);
      @(posedge clk) #1;
      chk("loopback", bus.MotorDataTx_ob64, rx);
      chk("loop_pins", pins_now(), pins_model(rx, 1'b1));
    end

    write_ch(1, 32'haabb_ccdd);
    read_ch(1, "ch1_echo", 32'haabb_ccdd);
    write_ch(0, 32'h0000_0001);
    read_ch(0, "ch0_page1", 32'haabb_ccdd);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rx = {$urandom, $urandom};
      bus.MotorDataRx_ib64 = rx;
      @(posedge clk) #1;
      chk("reopen_pins", pins_now(), pins_model(rx, 1'b0));
    end
    @(negedge clk);
    pf = 16'($urandom);
    sa = 16'($urandom);
    sb = 16'($urandom);
    bus.PlPfail_ib16  = pf;
    bus.PlSwOutA_ib16 = sa;
    bus.PlSwOutB_ib16 = sb;
    repeat (3) @(posedge clk);
    #1;
    chk("noloop_status", bus.MotorDataTx_ob64,
        status_model(pf, sa, sb));

    write_ch(1, GEFE_INTERLOCK);
    write_ch(0, 32'h8000_0000);
    @(negedge clk);
    rx = 64'hffff_ffff_ffff_ffff;
    bus.MotorDataRx_ib64 = rx;
    @(posedge clk) #1;
    chk("pre_rst_pins", pins_now(), pins_model(rx, 1'b1));
    chk("pre_rst_tx", bus.MotorDataTx_ob64, rx);
    @(negedge clk) #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pins", pins_now(), 64'd0);
    chk("mid_rst_tx", bus.MotorDataTx_ob64, 64'd0);
    bus.PlPfail_ib16  = '0;
    bus.PlSwOutA_ib16 = '0;
    bus.PlSwOutB_ib16 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_pins", pins_now(), pins_model(rx, 1'b0));
    chk("post_rst_tx", bus.MotorDataTx_ob64, 64'd0);
    read_ch(0, "post_rst_ch0", 32'h0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
